// File: rtl/router_sync_ctrl.sv
// ---------------------------------------------------------------------------
// router_sync_ctrl
//
// Per-packet port controller sitting between the router sequencing FSM and
// the three output FIFOs (ports 0..2).
//   - Latches the destination address on the FSM header cycle.
//   - Steers the FSM write strobe to the addressed FIFO (one-hot) and returns
//     that FIFO's full flag.
//   - Drives vld_out per port straight from the FIFO empty flags.
//   - Runs an independent read-timeout watchdog per port.  It pulses
//     soft_reset for one cycle when a port has held valid data for TIMEOUT
//     consecutive cycles without being read.
//
// Parameters
//   TIMEOUT : consecutive stalled cycles before soft_reset fires (>= 2)
//   CNT_W   : watchdog counter width, 2**CNT_W must be >= TIMEOUT
//
// Ports
//   clock            in   system clock, all state on the rising edge
//   resetn           in   asynchronous, active-low reset
//   detect_add       in   header cycle: latch data_in as the address
//   data_in[1:0]     in   destination address (00,01,10 valid; 11 invalid)
//   write_enb_reg    in   write strobe for the addressed FIFO
//   read_enb_0..2    in   external reader pops FIFO n
//   empty_0..2       in   FIFO n empty
//   full_0..2        in   FIFO n full
//   write_enb[2:0]   out  one-hot FIFO write enables
//   fifo_full        out  full flag of the addressed FIFO (0 for addr 11)
//   vld_out_0..2     out  FIFO n holds data
//   soft_reset_0..2  out  registered one-cycle timeout pulse for port n
// ---------------------------------------------------------------------------
module router_sync_ctrl #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam int unsigned NPORT = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Destination address register
  // -------------------------------------------------------------------------
  logic [1:0] addr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= '0;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  // -------------------------------------------------------------------------
  // Write-enable steering and full-flag return.
  // Decodes the registered address only, so a header cycle that overlaps a
  // write strobe still targets the previous packet's port and the one-hot
  // output can never show two ports at once.
  // -------------------------------------------------------------------------
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    unique case (addr)
      2'b00: begin
        write_enb[0] = write_enb_reg;
        fifo_full    = full_0;
      end
      2'b01: begin
        write_enb[1] = write_enb_reg;
        fifo_full    = full_1;
      end
      2'b10: begin
        write_enb[2] = write_enb_reg;
        fifo_full    = full_2;
      end
      default: begin
        // invalid address: no write, report not-full
        write_enb = '0;
        fifo_full = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Valid outputs: direct inversion of the FIFO empty flags.
  // -------------------------------------------------------------------------
  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  // -------------------------------------------------------------------------
  // Read-timeout watchdogs, one per port, fully independent of addr.
  // A port stalls when it holds data and its reader does not pop this cycle.
  // Any non-stalled cycle clears the count, so partial stalls never add up.
  // On the TIMEOUT-th consecutive stalled edge the pulse is raised and the
  // count restarts from zero, giving a one-cycle pulse every TIMEOUT cycles
  // while the stall persists.
  // -------------------------------------------------------------------------
  logic [NPORT-1:0] stall;
  logic [NPORT-1:0] soft_q;
  logic [CNT_W-1:0] cnt [NPORT];

  assign stall[0] = vld_out_0 & ~read_enb_0;
  assign stall[1] = vld_out_1 & ~read_enb_1;
  assign stall[2] = vld_out_2 & ~read_enb_2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        cnt[i] <= '0;
      end
      soft_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (!stall[i]) begin
          cnt[i]    <= '0;
          soft_q[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          soft_q[i] <= 1'b1;
        end else begin
          cnt[i]    <= cnt[i] + CNT_ONE;
          soft_q[i] <= 1'b0;
        end
      end
    end
  end

  assign soft_reset_0 = soft_q[0];
  assign soft_reset_1 = soft_q[1];
  assign soft_reset_2 = soft_q[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_router_sync_ctrl
// Directed self-checking bench for router_sync_ctrl (TIMEOUT=30, CNT_W=5).
// Inputs change 1 time unit after a rising edge; outputs are sampled then.
// ---------------------------------------------------------------------------
module tb_router_sync_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int errors = 0;
  int checks = 0;

  router_sync_ctrl #(
    .TIMEOUT (30),
    .CNT_W   (5)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_addr(input logic [1:0] a);
    detect_add = 1'b1;
    data_in    = a;
    tick();
    detect_add = 1'b0;
    data_in    = 2'b00;
    #1;
  endtask

  logic [2:0] fulls;
  int         first1, first2;
  bit         any_hi;

  initial begin
    resetn = 1'b0;
    detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    #12;
    // ---- reset state ----
    check("rst_write_enb", 32'(write_enb), 0);
    check("rst_fifo_full", 32'(fifo_full), 0);
    check("rst_soft", 32'({soft_reset_2, soft_reset_1, soft_reset_0}), 0);
    check("rst_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 0);
    resetn = 1'b1;
    tick();

    // ---- reset address is 00 ----
    write_enb_reg = 1'b1; full_0 = 1'b1; #1;
    check("rst_addr_decode", 32'(write_enb), 3'b001);
    check("rst_addr_full", 32'(fifo_full), 1);
    write_enb_reg = 1'b0; full_0 = 1'b0; #1;
    check("wr_reg_low", 32'(write_enb), 0);

    // ---- decode addr 10 ----
    load_addr(2'b10);
    write_enb_reg = 1'b1; full_2 = 1'b1; full_0 = 1'b0; full_1 = 1'b0; #1;
    check("dec10_we", 32'(write_enb), 3'b100);
    check("dec10_full_hi", 32'(fifo_full), 1);
    full_2 = 1'b0; full_0 = 1'b1; full_1 = 1'b1; #1;
    check("dec10_full_lo", 32'(fifo_full), 0);

    // ---- decode each valid address with one-hot and inverted full patterns ----
    for (int a = 0; a < 3; a++) begin
      write_enb_reg = 1'b0;
      load_addr(2'(a));
      write_enb_reg = 1'b1;
      fulls = 3'b001 << a;
      {full_2, full_1, full_0} = fulls; #1;
      check($sformatf("dec%0d_we", a), 32'(write_enb), 32'(3'b001 << a));
      check($sformatf("dec%0d_full1", a), 32'(fifo_full), 1);
      fulls = ~fulls;
      {full_2, full_1, full_0} = fulls; #1;
      check($sformatf("dec%0d_full0", a), 32'(fifo_full), 0);
    end

    // ---- invalid address 11 ----
    write_enb_reg = 1'b0;
    load_addr(2'b11);
    write_enb_reg = 1'b1; {full_2, full_1, full_0} = 3'b111; #1;
    check("dec11_we", 32'(write_enb), 0);
    check("dec11_full", 32'(fifo_full), 0);
    write_enb_reg = 1'b0; {full_2, full_1, full_0} = 3'b000;

    // ---- overlap: header and write in the same cycle ----
    load_addr(2'b01);
    detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b1; #1;
    check("ovl_old_addr", 32'(write_enb), 3'b010);
    tick();
    detect_add = 1'b0; #1;
    check("ovl_new_addr", 32'(write_enb), 3'b001);
    write_enb_reg = 1'b0; #1;
    check("ovl_wr_off", 32'(write_enb), 0);

    // ---- vld_out follows empty combinationally ----
    read_enb_0 = 1'b1; read_enb_1 = 1'b1; read_enb_2 = 1'b1;
    {empty_2, empty_1, empty_0} = 3'b010; #1;
    check("vld_pat_a", 32'({vld_out_2, vld_out_1, vld_out_0}), 3'b101);
    {empty_2, empty_1, empty_0} = 3'b101; #1;
    check("vld_pat_b", 32'({vld_out_2, vld_out_1, vld_out_0}), 3'b010);
    {empty_2, empty_1, empty_0} = 3'b111;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    tick();

    // ---- timeout on port 0: pulse exactly after the 30th stalled edge ----
    empty_0 = 1'b0;
    any_hi = 1'b0;
    for (int i = 1; i <= 29; i++) begin
      tick();
      if (soft_reset_0) any_hi = 1'b1;
    end
    check("to_no_early", 32'(any_hi), 0);
    tick();
    check("to_pulse_c31", 32'(soft_reset_0), 1);
    check("to_other_ports", 32'({soft_reset_2, soft_reset_1}), 0);
    tick();
    check("to_pulse_c32", 32'(soft_reset_0), 0);
    empty_0 = 1'b1;
    tick();

    // ---- near-miss: 29 stall, 1 read, 29 stall -> no pulse; 30th fires ----
    empty_0 = 1'b0;
    any_hi = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (soft_reset_0) any_hi = 1'b1;
    end
    read_enb_0 = 1'b1;
    tick();
    if (soft_reset_0) any_hi = 1'b1;
    read_enb_0 = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (soft_reset_0) any_hi = 1'b1;
    end
    check("near_miss", 32'(any_hi), 0);
    tick();
    check("near_miss_30th", 32'(soft_reset_0), 1);
    empty_0 = 1'b1;
    tick();
    check("near_miss_clear", 32'(soft_reset_0), 0);

    // ---- independence: ports 1 and 2 stall 5 cycles apart ----
    first1 = -1; first2 = -1; any_hi = 1'b0;
    empty_1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) empty_2 = 1'b0;
      tick();
      if (soft_reset_1 && first1 < 0) first1 = i + 1;
      if (soft_reset_2 && first2 < 0) first2 = i + 1;
      if (soft_reset_0) any_hi = 1'b1;
    end
    check("ind_p1_tick", 32'(first1), 30);
    check("ind_p2_tick", 32'(first2), 35);
    check("ind_p0_quiet", 32'(any_hi), 0);
    empty_1 = 1'b1; empty_2 = 1'b1;
    tick();

    // ---- reset mid-stall (cnt_1 = 17) ----
    load_addr(2'b10);
    empty_1 = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    #1;
    resetn = 1'b0; #1;
    check("midrst_soft1", 32'(soft_reset_1), 0);
    write_enb_reg = 1'b1; #1;
    check("midrst_addr", 32'(write_enb), 3'b001);
    write_enb_reg = 1'b0;
    #1;
    resetn = 1'b1;
    // stall persists; a full fresh 30 edges are needed after release
    any_hi = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (soft_reset_1) any_hi = 1'b1;
    end
    check("midrst_no_early", 32'(any_hi), 0);
    tick();
    check("midrst_fresh_pulse", 32'(soft_reset_1), 1);
    // reset while the pulse is high discards it immediately
    resetn = 1'b0; #1;
    check("rst_kills_pulse", 32'(soft_reset_1), 0);
    empty_1 = 1'b1;
    #2;
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
